gmii_tx_mac: RTL and testbench
==============================

Name: gmii_tx_mac

Overview:
- Ethernet TX framer placed directly upstream of the GMII-to-RGMII DDR output stage.
- Accepts frame bytes (destination MAC through payload) on a valid/ready byte stream.
- Emits complete GMII frames on gmii_tx_en, gmii_tx_er and gmii_tx_data: preamble, SFD, data, optional zero pad, FCS (CRC-32) and enforced inter-frame gap.
- Runs entirely in the gmii_tx_clk domain (125 MHz).

Parameters:
- PAD_EN, 1, 1 = pad short frames with 0x00 up to MIN_LEN before FCS; 0 = no padding.
- MIN_LEN, 60, minimum frame bytes before FCS (destination MAC through pad).
- MAX_LEN, 1514, maximum frame bytes before FCS; longer input is an error.
- IFG_LEN, 12, idle cycles forced after each frame, including aborted frames.

Ports:
- gmii_tx_clk  in  1  125 MHz TX clock.
- sys_rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input frame byte.
- s_last  in  1  marks the final input byte of a frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- gmii_tx_en  out  1  GMII transmit enable.
- gmii_tx_er  out  1  GMII transmit error.
- gmii_tx_data  out  8  GMII transmit data.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse in the cycle after the last FCS byte is driven.
- tx_error  out  1  one-cycle pulse on underrun or oversize.

Behaviour:
- Clock and reset: single clock gmii_tx_clk; sys_rst is synchronous and active-high.
- Reset values (next edge with sys_rst=1): state=IDLE, s_ready=0, gmii_tx_en=0, gmii_tx_er=0, gmii_tx_data=0x00, busy=0, frame_done=0, tx_error=0, counters=0, crc=0xFFFFFFFF.
- Reset mid-frame: the frame is abandoned immediately and no IFG is inserted.
- GMII outputs are registered. The value driven in cycle N+1 reflects state/input at edge N.
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE:
  - Waits for s_valid=1; s_valid is sampled only, no byte is consumed.
  - Then enters PRE.
- PRE:
  - Drives 0x55 with en=1 for 7 cycles, then moves to SFD.
- SFD:
  - Drives 0xD5 with en=1.
  - s_ready=1 in this cycle, so the first data byte is accepted here.
  - crc initialised to 0xFFFFFFFF.
- DATA:
  - s_ready=1 in SFD and DATA.
  - An accepted byte is driven on gmii_tx_data in the next cycle and folded into crc.
  - byte_cnt (11 bits) increments per accepted byte.
- Accepting s_last:
  - If PAD_EN and byte_cnt+1 < MIN_LEN, go to PAD; otherwise go to FCS.
  - s_ready drops in the cycle after s_last is accepted.
- PAD:
  - Drives 0x00, folded into crc, until the total byte count reaches MIN_LEN.
- FCS:
  - 4 cycles driving ~crc, LSB byte first: [7:0], [15:8], [23:16], [31:24].
  - gmii_tx_en falls in the cycle after the last FCS byte; frame_done pulses in that same cycle.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, processed LSB-first, 8 bits per clock.
  - Residue check: crc over data+FCS equals 0xDEBB20E3.
- IFG:
  - Drives en=0, data=0x00 for IFG_LEN cycles, then returns to IDLE.
  - A back-to-back frame with s_valid held high starts PRE on the cycle after IFG ends.
- Underrun (s_valid=0 in DATA before s_last):
  - Next cycle drives en=1, er=1, data=0x00 for one cycle and pulses tx_error.
  - Then enters DRAIN.
- Oversize (byte_cnt reaches MAX_LEN without s_last):
  - Same action as underrun: one error cycle, tx_error pulse, then DRAIN.
- DRAIN:
  - en=0, s_ready=1; input bytes are discarded up to and including s_last, then the FSM enters IFG.
  - s_last seen in the same cycle as the error event ends the drain immediately.
- busy=1 in all states except IDLE.
- Simultaneous s_valid and sys_rst: reset wins.

Decomposition:
- Package eth_tx_pkg holds:
  - state enum;
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF, CRC_POLY=0xEDB88320, CRC_RESIDUE=0xDEBB20E3.
- One sub-module: crc32_d8.
  - Purely combinational: next_crc from crc_in[31:0] and data[7:0].
  - The crc register itself lives in gmii_tx_mac.

Test Plan:
- PAD_EN=0, payload "123456789" (0x31..0x39) with s_last on 0x39 -> 7x0x55, 0xD5, 9 data bytes, FCS 0x26 0x39 0xF4 0xCB; en high for exactly 21 cycles; frame_done pulses once.
- PAD_EN=1, 14-byte frame -> 46 bytes of 0x00 pad; 60 data+pad bytes total; receiver-model residue 0xDEBB20E3; 72 en cycles.
- Two 64-byte frames with s_valid held high -> exactly 12 en=0 cycles between the frames; the second preamble starts on the 13th cycle.
- s_valid dropped after 20 of 64 bytes -> one cycle with en=1, er=1; tx_error pulses; remaining bytes consumed with en=0 until s_last; then 12-cycle IFG.
- 1600-byte input, MAX_LEN=1514 -> er asserted after the 1514th byte; bytes 1515..1600 drained; tx_error pulses once.
- sys_rst=1 during DATA byte 30 -> next cycle en=0, s_ready=0, busy=0; a new frame after reset is transmitted with correct FCS.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        DRAIN
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update, one byte per call, LSB first.
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble, SFD, data, pad, FCS and enforced inter-frame gap.
// state | meaning
// IDLE  | waiting for s_valid, nothing on the wire
// PRE   | preamble bytes going out (pre_cnt down to 0, then SFD)
// SFD   | SFD on the wire, first data byte accepted here
// DATA  | accepting and forwarding frame bytes
// PAD   | emitting zero pad up to MIN_LEN
// FCS   | emitting inverted crc, LSB byte first
// IFG   | idle gap timer (ifg_cnt down to 0)
// DRAIN | discarding input after an error, up to s_last
module gmii_tx_mac
    import eth_tx_pkg::*;
#(
    parameter bit PAD_EN  = 1'b1,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       sys_rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       tx_error
);

    localparam int IFG_W = $clog2(IFG_LEN + 1);

    tx_state_t        state, state_nxt;
    logic [2:0]       pre_cnt, pre_nxt;
    logic [10:0]      byte_cnt, cnt_nxt;
    logic [1:0]       fcs_cnt, fcs_nxt;
    logic [IFG_W-1:0] ifg_cnt, ifg_nxt;
    logic [31:0]      crc, crc_nxt, crc_fold, crc_inv;
    logic [7:0]       crc_din, data_nxt;
    logic             en_nxt, er_nxt, fd_nxt, te_nxt, accept;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_din),
        .crc_out (crc_fold)
    );

    // ready drops for one cycle at the length limit so the error cycle follows byte MAX_LEN
    assign s_ready = (state == SFD) || (state == DRAIN) ||
                     ((state == DATA) && (byte_cnt != 11'(MAX_LEN)));
    assign accept  = s_valid && s_ready;
    assign busy    = (state != IDLE);
    assign crc_din = (state == PAD) ? 8'h00 : s_data;
    assign crc_inv = ~crc;

    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        data_nxt  = 8'h00;
        fd_nxt    = 1'b0;
        te_nxt    = 1'b0;
        crc_nxt   = crc;
        cnt_nxt   = byte_cnt;
        pre_nxt   = pre_cnt;
        fcs_nxt   = fcs_cnt;
        ifg_nxt   = ifg_cnt;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_nxt = PRE;
                    en_nxt    = 1'b1;
                    data_nxt  = PREAMBLE_BYTE;
                    pre_nxt   = 3'd6;
                end
            end
            PRE: begin
                en_nxt = 1'b1;
                if (pre_cnt == 3'd0) begin
                    state_nxt = SFD;
                    data_nxt  = SFD_BYTE;
                    crc_nxt   = CRC_INIT;
                    cnt_nxt   = 11'd0;
                end else begin
                    data_nxt = PREAMBLE_BYTE;
                    pre_nxt  = pre_cnt - 3'd1;
                end
            end
            SFD, DATA: begin
                en_nxt = 1'b1;
                if (accept) begin
                    data_nxt  = s_data;
                    crc_nxt   = crc_fold;
                    cnt_nxt   = byte_cnt + 11'd1;
                    state_nxt = DATA;
                    if (s_last) begin
                        fcs_nxt   = 2'd0;
                        state_nxt = (PAD_EN && (cnt_nxt < 11'(MIN_LEN))) ? PAD : FCS;
                    end
                end else begin
                    er_nxt    = 1'b1;
                    te_nxt    = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            PAD: begin
                en_nxt  = 1'b1;
                crc_nxt = crc_fold;
                cnt_nxt = byte_cnt + 11'd1;
                if (cnt_nxt == 11'(MIN_LEN)) begin
                    fcs_nxt   = 2'd0;
                    state_nxt = FCS;
                end
            end
            FCS: begin
                en_nxt   = 1'b1;
                data_nxt = crc_inv[{fcs_cnt, 3'b000} +: 8];
                fcs_nxt  = fcs_cnt + 2'd1;
                if (fcs_cnt == 2'd3) begin
                    ifg_nxt   = IFG_W'(IFG_LEN - 1);
                    state_nxt = IFG;
                end
            end
            IFG: begin
                // only the FCS path loads the full count, so this marks a completed frame
                fd_nxt = (ifg_cnt == IFG_W'(IFG_LEN - 1));
                if (ifg_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    ifg_nxt = ifg_cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    ifg_nxt   = IFG_W'(IFG_LEN - 2);
                    state_nxt = IFG;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_tx_data <= 8'h00;
            frame_done   <= 1'b0;
            tx_error     <= 1'b0;
            crc          <= CRC_INIT;
            byte_cnt     <= 11'd0;
            pre_cnt      <= 3'd0;
            fcs_cnt      <= 2'd0;
            ifg_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            gmii_tx_en   <= en_nxt;
            gmii_tx_er   <= er_nxt;
            gmii_tx_data <= data_nxt;
            frame_done   <= fd_nxt;
            tx_error     <= te_nxt;
            crc          <= crc_nxt;
            byte_cnt     <= cnt_nxt;
            pre_cnt      <= pre_nxt;
            fcs_cnt      <= fcs_nxt;
            ifg_cnt      <= ifg_nxt;
        end
    end

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: one instance without padding, one with padding.
module tb_gmii_tx_mac;

    logic       clk = 1'b0;
    logic       sys_rst, s_valid, s_last, sel;
    logic [7:0] s_data;
    logic       v0, v1;
    logic       rdy0, en0, er0, busy0, fd0, te0;
    logic       rdy1, en1, er1, busy1, fd1, te1;
    logic [7:0] d0, d1;
    logic       rdy, en, er, busy, fd, te;
    logic [7:0] gd;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay [1600];
    logic [7:0] exp_b [21];

    logic       mon_on = 1'b0;
    logic [7:0] q_data [$];
    bit         q_en [$], q_er [$], q_fd [$], q_te [$], q_busy [$], q_last [$];
    logic [7:0] rxb [$];

    int n_en, n_er, n_fd, n_te, first_en, er_idx, te_idx, fd_idx;
    int runs, gap1, run1_len, last_acc, busy_fall;

    always #4 clk = ~clk;

    assign v0 = s_valid & ~sel;
    assign v1 = s_valid & sel;

    always_comb begin
        rdy  = sel ? rdy1  : rdy0;
        en   = sel ? en1   : en0;
        er   = sel ? er1   : er0;
        gd   = sel ? d1    : d0;
        busy = sel ? busy1 : busy0;
        fd   = sel ? fd1   : fd0;
        te   = sel ? te1   : te0;
    end

    gmii_tx_mac #(.PAD_EN(1'b0)) dut0 (
        .gmii_tx_clk (clk),  .sys_rst (sys_rst), .s_valid (v0), .s_data (s_data),
        .s_last (s_last),    .s_ready (rdy0),    .gmii_tx_en (en0), .gmii_tx_er (er0),
        .gmii_tx_data (d0),  .busy (busy0),      .frame_done (fd0), .tx_error (te0)
    );

    gmii_tx_mac #(.PAD_EN(1'b1)) dut1 (
        .gmii_tx_clk (clk),  .sys_rst (sys_rst), .s_valid (v1), .s_data (s_data),
        .s_last (s_last),    .s_ready (rdy1),    .gmii_tx_en (en1), .gmii_tx_er (er1),
        .gmii_tx_data (d1),  .busy (busy1),      .frame_done (fd1), .tx_error (te1)
    );

    // samples mid low-phase, after the driver has settled its inputs
    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            q_data.push_back(gd);
            q_en.push_back(en);
            q_er.push_back(er);
            q_fd.push_back(fd);
            q_te.push_back(te);
            q_busy.push_back(busy);
            q_last.push_back(s_valid & rdy & s_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_bytes(input int from, input int to, input int total);
        for (int i = from; i < to; i++) begin
            int t;
            t = 0;
            s_valid = 1'b1;
            s_data  = pay[i];
            s_last  = (i == total - 1);
            while (!rdy && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!rdy) begin
                chk("send_ready_timeout", 32'(rdy), 32'd1);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic mon_start();
        q_data.delete(); q_en.delete(); q_er.delete(); q_fd.delete();
        q_te.delete(); q_busy.delete(); q_last.delete();
        mon_on = 1'b1;
    endtask

    task automatic analyse();
        mon_on = 1'b0;
        n_en = 0; n_er = 0; n_fd = 0; n_te = 0;
        first_en = -1; er_idx = -1; te_idx = -1; fd_idx = -1;
        runs = 0; gap1 = 0; run1_len = 0; last_acc = -1; busy_fall = -1;
        rxb.delete();
        for (int i = 0; i < q_en.size(); i++) begin
            if (q_en[i]) begin
                n_en++;
                if (first_en < 0) first_en = i;
                if (i == 0 || !q_en[i-1]) runs++;
                if (runs == 1) run1_len++;
                if (!q_er[i]) rxb.push_back(q_data[i]);
            end else if (runs == 1) begin
                gap1++;
            end
            if (q_er[i]) begin
                n_er++;
                if (er_idx < 0) er_idx = i;
            end
            if (q_te[i]) begin
                n_te++;
                if (te_idx < 0) te_idx = i;
            end
            if (q_fd[i]) begin
                n_fd++;
                if (fd_idx < 0) fd_idx = i;
            end
            if (q_last[i]) last_acc = i;
        end
        for (int i = 0; i < q_busy.size(); i++) begin
            if (last_acc >= 0 && i > last_acc && !q_busy[i] && busy_fall < 0) busy_fall = i;
        end
    endtask

    // bitwise receiver model of the reflected CRC-32 register
    function automatic logic [31:0] model_crc(input int from, input int to);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < to; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ rxb[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    initial begin
        sys_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en0",    32'(en0),   32'd0);
        chk("rst_er0",    32'(er0),   32'd0);
        chk("rst_data0",  32'(d0),    32'd0);
        chk("rst_ready0", 32'(rdy0),  32'd0);
        chk("rst_busy0",  32'(busy0), 32'd0);
        chk("rst_done0",  32'(fd0),   32'd0);
        chk("rst_err0",   32'(te0),   32'd0);
        chk("rst_en1",    32'(en1),   32'd0);
        chk("rst_busy1",  32'(busy1), 32'd0);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // no padding, "123456789": check value 0xCBF43926 goes out LSB byte first
        sel = 1'b0;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
        exp_b[7] = 8'hD5;
        for (int i = 0; i < 9; i++) exp_b[8+i] = 8'h31 + 8'(i);
        exp_b[17] = 8'h26; exp_b[18] = 8'h39; exp_b[19] = 8'hF4; exp_b[20] = 8'hCB;
        mon_start();
        send_bytes(0, 9, 9);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t1_idle");
        analyse();
        chk("t1_en_cycles", 32'(n_en), 32'd21);
        chk("t1_wire_len",  32'(rxb.size()), 32'd21);
        for (int i = 0; i < 21; i++) begin
            if (i < rxb.size()) chk($sformatf("t1_byte%0d", i), 32'(rxb[i]), 32'(exp_b[i]));
        end
        chk("t1_done_count", 32'(n_fd), 32'd1);
        chk("t1_done_pos",   32'(fd_idx), 32'(first_en + 21));
        chk("t1_er_count",   32'(n_er), 32'd0);

        // padded 14-byte frame
        sel = 1'b1;
        for (int i = 0; i < 14; i++) pay[i] = 8'hA0 + 8'(i);
        mon_start();
        send_bytes(0, 14, 14);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t2_idle");
        analyse();
        chk("t2_en_cycles", 32'(n_en), 32'd72);
        chk("t2_wire_len",  32'(rxb.size()), 32'd72);
        if (rxb.size() == 72) begin
            chk("t2_last_data", 32'(rxb[21]), 32'h0000_00AD);
            chk("t2_first_pad", 32'(rxb[22]), 32'd0);
            chk("t2_last_pad",  32'(rxb[67]), 32'd0);
            chk("t2_residue",   model_crc(8, 72), 32'hDEBB_20E3);
        end
        chk("t2_done_count", 32'(n_fd), 32'd1);

        // two 64-byte frames back to back with s_valid held high
        for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3 + 1);
        mon_start();
        send_bytes(0, 64, 64);
        send_bytes(0, 64, 64);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t3_idle");
        analyse();
        chk("t3_runs",     32'(runs), 32'd2);
        chk("t3_gap",      32'(gap1), 32'd12);
        chk("t3_run1_len", 32'(run1_len), 32'd76);
        chk("t3_en_total", 32'(n_en), 32'd152);
        chk("t3_done",     32'(n_fd), 32'd2);
        if (rxb.size() >= 76) chk("t3_residue", model_crc(8, 76), 32'hDEBB_20E3);

        // underrun after 20 of 64 bytes
        mon_start();
        send_bytes(0, 20, 64);
        s_valid = 1'b0;
        @(negedge clk);
        send_bytes(20, 64, 64);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t4_idle");
        analyse();
        chk("t4_en_cycles", 32'(n_en), 32'd29);
        chk("t4_er_count",  32'(n_er), 32'd1);
        chk("t4_er_pos",    32'(er_idx), 32'(first_en + 28));
        chk("t4_err_count", 32'(n_te), 32'd1);
        chk("t4_err_pos",   32'(te_idx), 32'(er_idx));
        chk("t4_done",      32'(n_fd), 32'd0);
        chk("t4_ifg_end",   32'(busy_fall), 32'(last_acc + 12));

        // oversize: 1600 bytes against MAX_LEN 1514
        sel = 1'b0;
        for (int i = 0; i < 1600; i++) pay[i] = 8'(i);
        mon_start();
        send_bytes(0, 1600, 1600);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t5_idle");
        analyse();
        chk("t5_en_cycles", 32'(n_en), 32'd1523);
        chk("t5_er_pos",    32'(er_idx), 32'(first_en + 1522));
        chk("t5_err_count", 32'(n_te), 32'd1);
        chk("t5_done",      32'(n_fd), 32'd0);
        if (rxb.size() == 1522) chk("t5_byte1514", 32'(rxb[1521]), 32'(pay[1513]));
        chk("t5_ifg_end",   32'(busy_fall), 32'(last_acc + 12));

        // reset while byte 30 is offered, then a clean frame
        sel = 1'b1;
        for (int i = 0; i < 64; i++) pay[i] = 8'(8'h80 ^ 8'(i));
        send_bytes(0, 29, 64);
        s_valid = 1'b1; s_data = pay[29]; s_last = 1'b0; sys_rst = 1'b1;
        @(negedge clk);
        chk("t6_en",    32'(en1),   32'd0);
        chk("t6_ready", 32'(rdy1),  32'd0);
        chk("t6_busy",  32'(busy1), 32'd0);
        sys_rst = 1'b0; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        mon_start();
        send_bytes(0, 9, 9);
        s_valid = 1'b0; s_last = 1'b0;
        wait_idle("t6_idle");
        analyse();
        chk("t6_en_cycles", 32'(n_en), 32'd72);
        if (rxb.size() == 72) begin
            chk("t6_first_data", 32'(rxb[8]), 32'h0000_0031);
            chk("t6_residue",    model_crc(8, 72), 32'hDEBB_20E3);
        end
        chk("t6_done", 32'(n_fd), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
